mac_feeder: RTL and testbench
=============================

# mac_feeder

Sequencer that drives the operand side of the 16-lane MAC array. On a start command it streams `len` consecutive weight and activation vectors out of two single-port vector buffers and presents them as one valid beat per cycle. It then counts the MAC's `vld` returns and raises `done_o` once every issued beat has produced a result. It sits between the operand SRAMs and the `mac` block inside the convolution datapath.

## Interface
- `WI`, default 8: bits per lane element (unsigned activation, offset-coded weight; the MAC does the decoding).
- `N`, default 16: lanes per vector.
- `AW`, default 8: buffer address width; buffer depth is 2^AW.
- `clk`, input, 1: clock, rising edge.
- `rstn`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `start_i`, input, 1: command strobe, sampled only in IDLE.
- `len_i`, input, AW+1: number of vectors, 0..2^AW.
- `w_base_i`, input, AW: first weight address.
- `d_base_i`, input, AW: first activation address.
- `w_rd_en_o`, output, 1: weight buffer read enable.
- `w_addr_o`, output, AW: weight buffer address.
- `w_rdata_i`, input, N*WI: weight read data, valid 1 cycle after `w_rd_en_o`.
- `d_rd_en_o`, output, 1: activation buffer read enable.
- `d_addr_o`, output, AW: activation buffer address.
- `d_rdata_i`, input, N*WI: activation read data, valid 1 cycle after `d_rd_en_o`.
- `vld_o`, output, 1: operand beat valid; drives MAC `vld_i`.
- `win_o`, output, N*WI: weight vector; drives MAC `win`.
- `din_o`, output, N*WI: activation vector; drives MAC `din`.
- `mac_vld_i`, input, 1: MAC `vld_o` return.
- `busy_o`, output, 1: high in every state except IDLE.
- `done_o`, output, 1: one-cycle completion pulse.
- `err_o`, output, 1: sticky protocol error; cleared only by the next accepted start.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - `start_i`=1 latches `len_i`, both bases, clears the issue counter, the return counter and `err_o`.
  - If `len_i`=0, go to DONE. Otherwise go to ISSUE.
- **ISSUE:**
  - Each cycle asserts `w_rd_en_o` and `d_rd_en_o` together, with `w_addr_o`=w_base+k and `d_addr_o`=d_base+k (mod 2^AW; wraps from 2^AW-1 to 0). k is the issue count.
  - After the beat with k=len-1, go to DRAIN.
- **Read-data path:**
  - The read enable is delayed by one cycle to mark returning data.
  - On that marked cycle, `w_rdata_i`/`d_rdata_i` are registered into `win_o`/`din_o` and `vld_o`=1 for one cycle.
  - When `vld_o`=0, `win_o`/`din_o` hold their last value.
- **Return counting:**
  - The return counter (AW+1 bits) increments on every `mac_vld_i` in ISSUE or DRAIN.
- **DRAIN:**
  - When the return counter reaches len, go to DONE. This may be the same cycle the final return arrives during ISSUE only if len returns are already seen; in practice this happens in DRAIN.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Errors:**
  - `mac_vld_i` in IDLE or DONE sets `err_o`.
  - `mac_vld_i` arriving when the return count already equals len sets `err_o` and does not increment the counter.
- `start_i` outside IDLE is ignored and does not set `err_o`.
- Arithmetic: addresses modulo 2^AW. Counters are AW+1 bits so len=2^AW is exact.

## Timing
- Reset values:
  - State IDLE.
  - `w_rd_en_o`, `d_rd_en_o`, `vld_o`, `busy_o`, `done_o`, `err_o` = 0.
  - `w_addr_o`, `d_addr_o`, `win_o`, `din_o` = 0.
  - All counters = 0.
- Start accepted at edge T: first read enables are high in cycle T+1, first `vld_o` in cycle T+3.
- Issue rate is one beat per cycle. A len-L command issues its reads in cycles T+1..T+L, with no gaps unless stalled.
- Read enable to `vld_o`: 2 cycles, fixed (1 cycle buffer latency plus 1 output register).
- `done_o` is asserted in the cycle after the cycle in which the L-th `mac_vld_i` is sampled. For N=16 the MAC returns 5 cycles after each beat, so `done_o` falls at T+L+8.
- len=0: `busy_o` high for cycle T+1 only (DONE), `done_o` in T+1, no reads.
- Asynchronous reset mid-operation:
  - Every output returns to its reset value immediately.
  - In-flight beats are discarded.
  - The MAC must be reset together with the feeder; MAC returns arriving after reset, while the feeder is in IDLE, set `err_o`.

## Configuration
- `MAC_FEEDER_STALL_EN`
  - Defined: adds input `stall_i` (1 bit). In ISSUE, `stall_i`=1 suppresses both read enables and freezes k.
    - A read issued in the previous cycle still completes and produces its `vld_o` beat.
    - The MAC has no back-pressure, so stall is pacing only.
  - Undefined: the port is absent and ISSUE never pauses.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0, `busy_o`=0, `err_o`=0.
- len=4, bases 0/0x10, buffers hold an address-indexed pattern:
  - Reads at addresses 0..3 / 0x10..0x13 in T+1..T+4.
  - `vld_o` in T+3..T+6 with matching data.
  - `done_o` exactly once, after the 4th `mac_vld_i`.
- len=3, w_base=0xFE: weight addresses 0xFE, 0xFF, 0x00; `done_o` after 3 returns.
- len=0: no read enables, `done_o` in T+1, `busy_o` back to 0 in T+2.
- Spurious `mac_vld_i` in IDLE: `err_o`=1 and stays 1. The next start clears it. A 5th return on a len=4 command also sets it.
- Stall build (`MAC_FEEDER_STALL_EN` defined), len=4, `stall_i`=1 for 2 cycles after the 2nd read: addresses 0, 1, gap of 2 cycles, then 2, 3. `vld_o` has a matching 2-cycle gap and `done_o` still arrives after 4 returns.

Source files
------------

// File: rtl/mac_feeder.sv
// Operand sequencer for the 16-lane MAC array: streams len weight/activation vectors, then counts MAC returns.
// Optional build macro MAC_FEEDER_STALL_EN adds stall_i pacing of the ISSUE phase.
module mac_feeder #(
    parameter int WI = 8,
    parameter int N  = 16,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [AW:0]     len_i,
    input  logic [AW-1:0]   w_base_i,
    input  logic [AW-1:0]   d_base_i,
`ifdef MAC_FEEDER_STALL_EN
    input  logic            stall_i,
`endif
    output logic            w_rd_en_o,
    output logic [AW-1:0]   w_addr_o,
    input  logic [N*WI-1:0] w_rdata_i,
    output logic            d_rd_en_o,
    output logic [AW-1:0]   d_addr_o,
    input  logic [N*WI-1:0] d_rdata_i,
    output logic            vld_o,
    output logic [N*WI-1:0] win_o,
    output logic [N*WI-1:0] din_o,
    input  logic            mac_vld_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW:0]   len_q;
    logic [AW:0]   k_q;
    logic [AW:0]   ret_q;
    logic [AW-1:0] w_base_q;
    logic [AW-1:0] d_base_q;
    logic          rd_en_q;
    logic          rd_q;
    logic          stall;
    logic          ret_full;
    logic          ret_inc;
    logic [AW:0]   ret_next;

`ifdef MAC_FEEDER_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign w_rd_en_o = rd_en_q;
    assign d_rd_en_o = rd_en_q;

    // A return beyond len is an error and must not advance the counter.
    always_comb begin
        ret_full = (ret_q == len_q);
        ret_inc  = mac_vld_i && !ret_full;
        ret_next = ret_q + {{AW{1'b0}}, ret_inc};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            len_q    <= '0;
            k_q      <= '0;
            ret_q    <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
            rd_en_q  <= 1'b0;
            rd_q     <= 1'b0;
            w_addr_o <= '0;
            d_addr_o <= '0;
            vld_o    <= 1'b0;
            win_o    <= '0;
            din_o    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_o  <= 1'b0;
            rd_q    <= rd_en_q;
            vld_o   <= rd_q;
            if (rd_q) begin
                win_o <= w_rdata_i;
                din_o <= d_rdata_i;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        w_base_q <= w_base_i;
                        d_base_q <= d_base_i;
                        ret_q    <= '0;
                        err_o    <= mac_vld_i;
                        busy_o   <= 1'b1;
                        if (len_i == '0) begin
                            k_q    <= '0;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            // First beat issues straight out of IDLE so reads start at T+1.
                            k_q      <= {{AW{1'b0}}, 1'b1};
                            rd_en_q  <= 1'b1;
                            w_addr_o <= w_base_i;
                            d_addr_o <= d_base_i;
                            state    <= ISSUE;
                        end
                    end else if (mac_vld_i) begin
                        err_o <= 1'b1;
                    end
                end

                ISSUE: begin
                    ret_q <= ret_next;
                    if (mac_vld_i && ret_full) err_o <= 1'b1;
                    if (k_q == len_q) begin
                        state <= DRAIN;
                    end else if (!stall) begin
                        rd_en_q  <= 1'b1;
                        w_addr_o <= w_base_q + k_q[AW-1:0];
                        d_addr_o <= d_base_q + k_q[AW-1:0];
                        k_q      <= k_q + 1'b1;
                    end
                end

                DRAIN: begin
                    ret_q <= ret_next;
                    if (mac_vld_i && ret_full) err_o <= 1'b1;
                    if (ret_next == len_q) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    if (mac_vld_i) err_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed table-driven bench for mac_feeder with a 1-cycle buffer model and a 5-cycle MAC return model.
// Build with MAC_FEEDER_STALL_EN defined to also exercise the stall vector.
module tb_mac_feeder;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start_i = 1'b0;
    logic [8:0]   len_i = '0;
    logic [7:0]   w_base_i = '0;
    logic [7:0]   d_base_i = '0;
`ifdef MAC_FEEDER_STALL_EN
    logic         stall_i = 1'b0;
`endif
    logic         w_rd_en_o, d_rd_en_o;
    logic [7:0]   w_addr_o, d_addr_o;
    logic [127:0] w_rdata_i = '0;
    logic [127:0] d_rdata_i = '0;
    logic         vld_o;
    logic [127:0] win_o, din_o;
    logic         mac_vld_i;
    logic         busy_o, done_o, err_o;
    logic         extra_vld = 1'b0;
    logic [4:0]   mac_pipe;

    int total = 0;
    int bad = 0;

    mac_feeder #(.WI(8), .N(16), .AW(8)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i),
        .w_base_i(w_base_i), .d_base_i(d_base_i),
`ifdef MAC_FEEDER_STALL_EN
        .stall_i(stall_i),
`endif
        .w_rd_en_o(w_rd_en_o), .w_addr_o(w_addr_o), .w_rdata_i(w_rdata_i),
        .d_rd_en_o(d_rd_en_o), .d_addr_o(d_addr_o), .d_rdata_i(d_rdata_i),
        .vld_o(vld_o), .win_o(win_o), .din_o(din_o), .mac_vld_i(mac_vld_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] wpat(input logic [7:0] a);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = a + 8'(j);
        return r;
    endfunction

    function automatic logic [127:0] dpat(input logic [7:0] a);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = (~a) ^ 8'(j * 17);
        return r;
    endfunction

    // Single-port buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (w_rd_en_o) w_rdata_i <= wpat(w_addr_o);
        if (d_rd_en_o) d_rdata_i <= dpat(d_addr_o);
    end

    // MAC returns each beat 5 cycles later; it is reset together with the feeder.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) mac_pipe <= '0;
        else       mac_pipe <= {mac_pipe[3:0], vld_o};
    end
    assign mac_vld_i = mac_pipe[4] | extra_vld;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         len;
        logic [7:0] wb;
        logic [7:0] db;
        int         dexp;   // cycle after start edge in which done_o is high
        int         stall;  // 1: stall for 2 cycles after the 2nd read
        int         extra;  // cycle in which a spurious return is injected (0 = none)
    } vec_t;

    task automatic run_cmd(input vec_t v);
        bit         rd_e, vld_e, err_e;
        int         ri, vi;
        logic [7:0] wa, da;
        @(negedge clk);
        start_i  = 1'b1;
        len_i    = 9'(v.len);
        w_base_i = v.wb;
        d_base_i = v.db;
        for (int c = 1; c <= v.dexp + 2; c++) begin
            @(negedge clk);
            if (v.stall == 0) begin
                rd_e  = (c >= 1) && (c <= v.len);
                ri    = c - 1;
                vld_e = (c >= 3) && (c <= v.len + 2);
                vi    = c - 3;
            end else begin
                rd_e  = (c == 1) || (c == 2) || (c == 5) || (c == 6);
                ri    = (c <= 2) ? c - 1 : c - 3;
                vld_e = (c == 3) || (c == 4) || (c == 7) || (c == 8);
                vi    = (c <= 4) ? c - 3 : c - 5;
            end
            err_e = (v.extra > 0) && (c > v.extra);
            chk("w_rd_en", 128'(w_rd_en_o), 128'(rd_e));
            chk("d_rd_en", 128'(d_rd_en_o), 128'(rd_e));
            if (rd_e) begin
                wa = v.wb + 8'(ri);
                da = v.db + 8'(ri);
                chk("w_addr", 128'(w_addr_o), 128'(wa));
                chk("d_addr", 128'(d_addr_o), 128'(da));
            end
            chk("vld", 128'(vld_o), 128'(vld_e));
            if (vld_e) begin
                wa = v.wb + 8'(vi);
                da = v.db + 8'(vi);
                chk("win", win_o, wpat(wa));
                chk("din", din_o, dpat(da));
            end
            chk("done", 128'(done_o), 128'(c == v.dexp));
            chk("busy", 128'(busy_o), 128'(c <= v.dexp));
            chk("err", 128'(err_o), 128'(err_e));
            start_i   = 1'b0;
            extra_vld = (c == v.extra);
`ifdef MAC_FEEDER_STALL_EN
            stall_i = (v.stall != 0) && (c == 2 || c == 3);
`endif
        end
        extra_vld = 1'b0;
    endtask

    vec_t tv[6];
    vec_t vs;

    initial begin
        tv[0] = '{len: 4,   wb: 8'h00, db: 8'h10, dexp: 12,  stall: 0, extra: 0};
        tv[1] = '{len: 3,   wb: 8'hFE, db: 8'h20, dexp: 11,  stall: 0, extra: 0};
        tv[2] = '{len: 0,   wb: 8'h05, db: 8'h07, dexp: 1,   stall: 0, extra: 0};
        tv[3] = '{len: 1,   wb: 8'hFF, db: 8'hFF, dexp: 9,   stall: 0, extra: 0};
        tv[4] = '{len: 4,   wb: 8'h40, db: 8'h80, dexp: 12,  stall: 0, extra: 12};
        tv[5] = '{len: 256, wb: 8'h80, db: 8'h00, dexp: 264, stall: 0, extra: 0};
        vs    = '{len: 4,   wb: 8'h00, db: 8'h10, dexp: 14,  stall: 1, extra: 0};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst w_rd_en", 128'(w_rd_en_o), '0);
        chk("rst d_rd_en", 128'(d_rd_en_o), '0);
        chk("rst w_addr", 128'(w_addr_o), '0);
        chk("rst d_addr", 128'(d_addr_o), '0);
        chk("rst vld", 128'(vld_o), '0);
        chk("rst win", win_o, '0);
        chk("rst din", din_o, '0);
        chk("rst busy", 128'(busy_o), '0);
        chk("rst done", 128'(done_o), '0);
        chk("rst err", 128'(err_o), '0);

        // Spurious return while idle: err_o sets and stays set.
        extra_vld = 1'b1;
        @(negedge clk);
        extra_vld = 1'b0;
        chk("idle spurious err", 128'(err_o), 128'(1));
        repeat (3) @(negedge clk);
        chk("idle err sticky", 128'(err_o), 128'(1));

        for (int i = 0; i < 6; i++) run_cmd(tv[i]);

`ifdef MAC_FEEDER_STALL_EN
        run_cmd(vs);
`endif

        // Asynchronous reset in the middle of a command.
        @(negedge clk);
        start_i  = 1'b1;
        len_i    = 9'd8;
        w_base_i = 8'h33;
        d_base_i = 8'h44;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 128'(busy_o), 128'(1));
        #2 rstn = 1'b0;
        #1;
        chk("async w_rd_en", 128'(w_rd_en_o), '0);
        chk("async w_addr", 128'(w_addr_o), '0);
        chk("async vld", 128'(vld_o), '0);
        chk("async win", win_o, '0);
        chk("async busy", 128'(busy_o), '0);
        chk("async err", 128'(err_o), '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        chk("post-reset vld", 128'(vld_o), '0);
        chk("post-reset err", 128'(err_o), '0);
        run_cmd(tv[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
